// File: rtl/roach_rst_sequencer.sv
// Reset and bring-up sequencer for the ROACH2 clock infrastructure: waits for stable locks,
// pulses the IDELAYCTRL reset, waits for ready with retry, then releases domain resets in order.
module roach_rst_sequencer #(
  parameter int N_LOCK       = 2,
  parameter int N_DOM        = 4,
  parameter int LOCK_HOLD    = 1024,
  parameter int IDLY_RST_CYC = 64,
  parameter int RDY_TIMEOUT  = 4096,
  parameter int STAGGER      = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_LOCK-1:0] lock_in,
  input  logic              idelay_rdy,
  input  logic              clear_fault,
  output logic              idelay_rst,
  output logic [N_DOM-1:0]  dom_rst,
  output logic              all_ready,
  output logic              fault,
  output logic [7:0]        retry_cnt,
  output logic [15:0]       lock_loss_cnt,
  output logic [2:0]        state
);

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_IDLY_RST  = 3'd1;
  localparam logic [2:0] S_WAIT_RDY  = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAULT     = 3'd5;

  localparam int REL_CYC = STAGGER * N_DOM;
  localparam int MAX_A   = (LOCK_HOLD > IDLY_RST_CYC) ? LOCK_HOLD : IDLY_RST_CYC;
  localparam int MAX_B   = (RDY_TIMEOUT > REL_CYC) ? RDY_TIMEOUT : REL_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HOLD_DONE = cnt_t'(LOCK_HOLD);
  localparam cnt_t IDLY_LAST = cnt_t'(IDLY_RST_CYC - 1);
  localparam cnt_t RDY_LAST  = cnt_t'(RDY_TIMEOUT - 1);
  // RUN is entered one cycle before the last release so all_ready rises with it.
  localparam cnt_t REL_LAST  = cnt_t'((REL_CYC >= 2) ? REL_CYC - 2 : 0);

  logic [N_LOCK-1:0] lock_meta_q, lock_sync_q;
  logic              rdy_meta_q, rdy_sync_q;

  logic [2:0]       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d, retry_inc;
  logic [15:0]      loss_cnt_q, loss_cnt_d;
  logic             idelay_rst_q, idelay_rst_d;
  logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
  logic             all_ready_q, all_ready_d;
  logic             fault_q, fault_d;

  logic lk;
  logic loss;

  assign lk   = &lock_sync_q;
  assign loss = !lk && (state_q == S_IDLY_RST || state_q == S_WAIT_RDY ||
                        state_q == S_RELEASE  || state_q == S_RUN);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    loss_cnt_d = loss_cnt_q;
    retry_inc  = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    if (loss) begin
      state_d    = S_WAIT_LOCK;
      loss_cnt_d = (loss_cnt_q == 16'hFFFF) ? loss_cnt_q : loss_cnt_q + 16'd1;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          if (!lk)                    cnt_d   = '0;
          else if (cnt_q == HOLD_DONE) state_d = S_IDLY_RST;
          else                        cnt_d   = cnt_q + 1'b1;
        end
        S_IDLY_RST: begin
          if (cnt_q == IDLY_LAST) state_d = S_WAIT_RDY;
          else                    cnt_d   = cnt_q + 1'b1;
        end
        S_WAIT_RDY: begin
          if (rdy_sync_q) begin
            state_d = S_RELEASE;
          end else if (cnt_q == RDY_LAST) begin
            retry_d = retry_inc;
            state_d = (int'(retry_inc) <= MAX_RETRY) ? S_IDLY_RST : S_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q >= REL_LAST) state_d = S_RUN;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        S_RUN: ;
        S_FAULT: begin
          if (clear_fault) state_d = S_WAIT_LOCK;
        end
        default: state_d = S_WAIT_LOCK;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_WAIT_LOCK && state_q != S_WAIT_LOCK) retry_d = '0;

    // Outputs follow the current state one cycle later; a lock loss forces them safe at once.
    idelay_rst_d = (state_q == S_IDLY_RST) && !loss;
    all_ready_d  = (state_q == S_RUN) && !loss;
    fault_d      = (state_q == S_FAULT);
    dom_rst_d    = '1;
    if (!loss && state_q == S_RUN) dom_rst_d = '0;
    if (!loss && state_q == S_RELEASE) begin
      for (int i = 0; i < N_DOM; i++) begin
        dom_rst_d[i] = !(cnt_q >= cnt_t'(STAGGER * (i + 1) - 1));
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lock_meta_q  <= '0;
      lock_sync_q  <= '0;
      rdy_meta_q   <= 1'b0;
      rdy_sync_q   <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_cnt_q   <= '0;
      idelay_rst_q <= 1'b0;
      dom_rst_q    <= '1;
      all_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the order.
      lock_meta_q  <= lock_in;
      lock_sync_q  <= lock_meta_q;
      rdy_meta_q   <= idelay_rdy;
      rdy_sync_q   <= rdy_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_cnt_q   <= loss_cnt_d;
      idelay_rst_q <= idelay_rst_d;
      dom_rst_q    <= dom_rst_d;
      all_ready_q  <= all_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign idelay_rst    = idelay_rst_q;
  assign dom_rst       = dom_rst_q;
  assign all_ready     = all_ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_roach_rst_sequencer.sv
// Bench for roach_rst_sequencer: a timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_roach_rst_sequencer;

  localparam int LH = 8;
  localparam int IC = 4;
  localparam int RT = 16;
  localparam int ST = 2;
  localparam int MR = 2;
  localparam int ND = 4;

  localparam logic [2:0] WL = 3'd0, IR = 3'd1, WR = 3'd2, RL = 3'd3, RN = 3'd4, FT = 3'd5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  lock_in;
  logic        idelay_rdy;
  logic        clear_fault;
  logic        idelay_rst;
  logic [3:0]  dom_rst;
  logic        all_ready;
  logic        fault;
  logic [7:0]  retry_cnt;
  logic [15:0] lock_loss_cnt;
  logic [2:0]  state;

  roach_rst_sequencer #(
    .N_LOCK(2), .N_DOM(ND), .LOCK_HOLD(LH), .IDLY_RST_CYC(IC),
    .RDY_TIMEOUT(RT), .STAGGER(ST), .MAX_RETRY(MR)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .lock_in      (lock_in),
    .idelay_rdy   (idelay_rdy),
    .clear_fault  (clear_fault),
    .idelay_rst   (idelay_rst),
    .dom_rst      (dom_rst),
    .all_ready    (all_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state        (state)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases are tracked by entry timestamps and elapsed edge counts.
  typedef struct packed {
    logic [2:0] st;
    int         cyc;
    int         entered;
    int         lk_since;
    int         retries;
    int         losses;
    logic [1:0] lk_s1;
    logic [1:0] lk_s2;
    logic       rdy_s1;
    logic       rdy_s2;
    logic       idelay_rst;
    logic [3:0] dom;
    logic       all_ready;
    logic       fault;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r     = '0;
    r.dom = '1;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [1:0] lk_in,
                                        input logic rdy_in, input logic clr);
    model_t n;
    int     c;
    int     el;
    logic   lk;
    logic   rdy;
    logic   lost;
    n        = m;
    c        = m.cyc + 1;
    n.cyc    = c;
    n.lk_s1  = lk_in;
    n.lk_s2  = m.lk_s1;
    n.rdy_s1 = rdy_in;
    n.rdy_s2 = m.rdy_s1;
    lk       = &m.lk_s2;
    rdy      = m.rdy_s2;
    el       = c - m.entered;
    lost     = !lk && (m.st inside {IR, WR, RL, RN});

    n.idelay_rst = (m.st == IR) && !lost;
    n.all_ready  = (m.st == RN) && !lost;
    n.fault      = (m.st == FT);
    n.dom        = '1;
    if (!lost && m.st == RN) n.dom = '0;
    if (!lost && m.st == RL)
      for (int i = 0; i < ND; i++) n.dom[i] = (el < ST * (i + 1));

    if (lost) begin
      n.st     = WL;
      n.losses = (m.losses < 65535) ? m.losses + 1 : m.losses;
    end else begin
      case (m.st)
        WL: if (!lk) n.lk_since = c; else if (c - m.lk_since > LH) n.st = IR;
        IR: if (el == IC) n.st = WR;
        WR: begin
          if (rdy) n.st = RL;
          else if (el == RT) begin
            n.retries = (m.retries < 255) ? m.retries + 1 : m.retries;
            n.st      = (n.retries <= MR) ? IR : FT;
          end
        end
        RL: if (el == ST * ND - 1) n.st = RN;
        FT: if (clr) n.st = WL;
        default: ;
      endcase
    end

    if (n.st != m.st) begin
      n.entered = c;
      if (n.st == WL) begin
        n.retries  = 0;
        n.lk_since = c;
      end
    end
    return n;
  endfunction

  model_t m;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= model_reset();
    else            m <= model_step(m, lock_in, idelay_rdy, clear_fault);
  end

  always @(negedge sys_clk) begin
    check("m_state",      32'(state),         32'(m.st));
    check("m_idelay_rst", 32'(idelay_rst),    32'(m.idelay_rst));
    check("m_dom_rst",    32'(dom_rst),       32'(m.dom));
    check("m_all_ready",  32'(all_ready),     32'(m.all_ready));
    check("m_fault",      32'(fault),         32'(m.fault));
    check("m_retry_cnt",  32'(retry_cnt),     32'(m.retries));
    check("m_loss_cnt",   32'(lock_loss_cnt), 32'(m.losses));
  end

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_state", 32'(state), 32'(s));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},  32'(state),         32'(WL));
    check({tag, "_dom"},    32'(dom_rst),       32'h0000_000F);
    check({tag, "_idly"},   32'(idelay_rst),    32'h0);
    check({tag, "_ready"},  32'(all_ready),     32'h0);
    check({tag, "_fault"},  32'(fault),         32'h0);
    check({tag, "_retry"},  32'(retry_cnt),     32'h0);
    check({tag, "_loss"},   32'(lock_loss_cnt), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         pulses;
    int         nret;
    logic       prev_idly;
    logic [7:0] prev_retry;
    logic [7:0] rets [0:7];
    logic [3:0] dom_seen [1:8];
    logic       rdy_seen [1:8];

    sys_rst_n = 1'b0; lock_in = 2'b00; idelay_rdy = 1'b0; clear_fault = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_values("rst");

    // Nominal bring-up
    @(negedge sys_clk); sys_rst_n = 1'b1; lock_in = 2'b11;
    wait_state(IR, 40, n);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      if (idelay_rst) pulses++;
    end
    check("idly_pulse_len", 32'(pulses), 32'd4);
    check("in_wait_rdy", 32'(state), 32'(WR));
    repeat (4) @(negedge sys_clk);
    idelay_rdy = 1'b1;
    wait_state(RL, 20, n);
    for (int t = 1; t <= 8; t++) begin
      @(negedge sys_clk);
      dom_seen[t] = dom_rst;
      rdy_seen[t] = all_ready;
    end
    check("dom_t1", 32'(dom_seen[1]), 32'hF);
    check("dom_t2", 32'(dom_seen[2]), 32'hE);
    check("dom_t3", 32'(dom_seen[3]), 32'hE);
    check("dom_t4", 32'(dom_seen[4]), 32'hC);
    check("dom_t6", 32'(dom_seen[6]), 32'h8);
    check("dom_t8", 32'(dom_seen[8]), 32'h0);
    check("ready_t7", 32'(rdy_seen[7]), 32'h0);
    check("ready_t8", 32'(rdy_seen[8]), 32'h1);
    check("run_state", 32'(state), 32'(RN));

    // Lock loss in RUN
    @(negedge sys_clk); lock_in = 2'b10;
    repeat (2) @(negedge sys_clk);
    check("run_before_loss", 32'(all_ready), 32'h1);
    @(negedge sys_clk);
    check("loss1_state", 32'(state), 32'(WL));
    check("loss1_dom", 32'(dom_rst), 32'hF);
    check("loss1_ready", 32'(all_ready), 32'h0);
    check("loss1_cnt", 32'(lock_loss_cnt), 32'd1);
    lock_in = 2'b11;

    // Lock loss mid-RELEASE with dom_rst at 1100
    wait_state(RL, 60, n);
    repeat (3) @(negedge sys_clk);
    lock_in = 2'b10;
    repeat (2) @(negedge sys_clk);
    check("rel_dom_1100", 32'(dom_rst), 32'hC);
    @(negedge sys_clk);
    check("loss2_state", 32'(state), 32'(WL));
    check("loss2_dom", 32'(dom_rst), 32'hF);
    check("loss2_ready", 32'(all_ready), 32'h0);
    check("loss2_cnt", 32'(lock_loss_cnt), 32'd2);
    lock_in = 2'b11;
    wait_state(RN, 60, n);
    @(negedge sys_clk);
    check("resequence_ready", 32'(all_ready), 32'h1);

    // Lock glitch during hold, from a fresh reset
    @(negedge sys_clk); sys_rst_n = 1'b0; lock_in = 2'b00; idelay_rdy = 1'b0;
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(negedge sys_clk); lock_in = 2'b11;
    repeat (6) @(negedge sys_clk);
    lock_in = 2'b10;
    @(negedge sys_clk); lock_in = 2'b11;
    wait_state(IR, 40, n);
    check("hold_restart_cycles", 32'(n), 32'd11);
    check("glitch_loss_cnt", 32'(lock_loss_cnt), 32'd0);

    // Ready timeout with retries into FAULT
    pulses = 0; nret = 0; prev_idly = idelay_rst; prev_retry = retry_cnt; n = 0;
    while (state !== FT && n < 300) begin
      @(negedge sys_clk);
      n++;
      if (idelay_rst && !prev_idly) pulses++;
      if (retry_cnt !== prev_retry && nret < 8) begin
        rets[nret] = retry_cnt;
        nret++;
      end
      prev_idly  = idelay_rst;
      prev_retry = retry_cnt;
    end
    check("fault_state", 32'(state), 32'(FT));
    check("retry_pulses", 32'(pulses), 32'd3);
    check("retry_steps", 32'(nret), 32'd3);
    check("retry_1", 32'(rets[0]), 32'd1);
    check("retry_2", 32'(rets[1]), 32'd2);
    check("retry_3", 32'(rets[2]), 32'd3);
    check("fault_lags", 32'(fault), 32'h0);
    @(negedge sys_clk);
    check("fault_high", 32'(fault), 32'h1);
    check("fault_dom", 32'(dom_rst), 32'hF);
    @(negedge sys_clk); clear_fault = 1'b1;
    @(negedge sys_clk); clear_fault = 1'b0;
    check("clear_state", 32'(state), 32'(WL));
    check("clear_retry", 32'(retry_cnt), 32'd0);
    @(negedge sys_clk);
    check("clear_fault_low", 32'(fault), 32'h0);

    // Lock drop coincident with ready
    wait_state(WR, 60, n);
    repeat (2) @(negedge sys_clk);
    lock_in = 2'b01; idelay_rdy = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("coinc_rdy_pre", 32'(state), 32'(WR));
    @(negedge sys_clk);
    check("coinc_rdy_state", 32'(state), 32'(WL));
    check("coinc_rdy_loss", 32'(lock_loss_cnt), 32'd1);
    lock_in = 2'b11; idelay_rdy = 1'b0;

    // Lock drop coincident with a timeout
    wait_state(WR, 60, n);
    wait_state(IR, 40, n);
    wait_state(WR, 20, n);
    check("coinc_to_retry1", 32'(retry_cnt), 32'd1);
    repeat (13) @(negedge sys_clk);
    lock_in = 2'b10;
    repeat (2) @(negedge sys_clk);
    check("coinc_to_pre", 32'(state), 32'(WR));
    @(negedge sys_clk);
    check("coinc_to_state", 32'(state), 32'(WL));
    check("coinc_to_retry", 32'(retry_cnt), 32'd0);
    check("coinc_to_loss", 32'(lock_loss_cnt), 32'd2);
    lock_in = 2'b11; idelay_rdy = 1'b1;

    // Async reset mid-RELEASE
    wait_state(RL, 60, n);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge sys_clk); sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
